// File: rtl/fport_frame_decoder.sv
// Streaming FrSky F.Port frame decoder: destuffs, checksums and unpacks control
// frames byte by byte, committing channels/RSSI/flags only after a clean frame end.
module fport_frame_decoder #(
  parameter int CLK_FREQ     = 16000000,
  parameter int NUM_CHANNELS = 16,
  parameter int TIMEOUT_MS   = 100
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [7:0]                 rxData,
  input  logic                       rxDataAvail,
  output logic [NUM_CHANNELS*11-1:0] controls,
  output logic                       controlFrameReady,
  output logic                       crcError,
  output logic [7:0]                 rssi,
  output logic                       failsafe,
  output logic                       rxFrameLoss,
  output logic                       linkTimeout
);

  localparam longint TimeoutCyclesL = longint'(TIMEOUT_MS) * longint'(CLK_FREQ) / 64'sd1000;
  localparam int     TimeoutCycles  = (TimeoutCyclesL < 1) ? 1 : int'(TimeoutCyclesL);
  localparam int     CntWidth       = $clog2(TimeoutCycles + 1);

  typedef enum logic [2:0] {
    HUNT,
    LEN,
    TYPE,
    BODY,
    CRC,
    END
  } state_t;

  state_t state;
  state_t nextState;

  logic                       escPending;
  logic [7:0]                 lenReg;
  logic [7:0]                 checksum;
  logic                       isControl;
  logic                       crcOk;
  logic [4:0]                 bodyCount;
  logic [17:0]                bitBuf;
  logic [4:0]                 bitCount;
  logic [4:0]                 chanIdx;
  logic [NUM_CHANNELS*11-1:0] shadowControls;
  logic [7:0]                 shadowRssi;
  logic                       shadowFrameLoss;
  logic                       shadowFailsafe;
  logic                       failsafeFlag;
  logic [CntWidth-1:0]        timeoutCount;

  logic                       inRegion;
  logic                       rawFlag;
  logic                       dataByte;
  logic [7:0]                 destuffed;
  logic [7:0]                 sumNext;
  logic [8:0]                 sumWide;
  logic [17:0]                merged;
  logic [4:0]                 mergedCount;
  logic                       chanReady;
  logic                       lenOk;
  logic                       typeOk;
  logic                       bodyLast;
  logic                       commit;
  logic                       crcFail;

  // Byte classification: a data byte is any destuffed byte inside LEN..CRC
  always_comb begin
    inRegion    = (state == LEN) || (state == TYPE) || (state == BODY) || (state == CRC);
    rawFlag     = (rxData == 8'h7E);
    destuffed   = escPending ? (rxData ^ 8'h20) : rxData;
    dataByte    = rxDataAvail && inRegion && !rawFlag && (escPending || (rxData != 8'h7D));
    sumWide     = {1'b0, checksum} + {1'b0, destuffed};
    sumNext     = sumWide[7:0] + {7'b0, sumWide[8]};
    merged      = bitBuf | (18'(destuffed) << bitCount);
    mergedCount = bitCount + 5'd8;
    chanReady   = (mergedCount >= 5'd11);
    lenOk       = (destuffed == 8'h19) || (destuffed == 8'h08);
    typeOk      = ((destuffed == 8'h00) && (lenReg == 8'h19)) ||
                  (((destuffed == 8'h01) || (destuffed == 8'h81)) && (lenReg == 8'h08));
    bodyLast    = ({3'b000, bodyCount} == (lenReg - 8'd2));
  end

  // Next-state decode; commit/crcFail are only raised by the closing flag
  always_comb begin
    nextState = state;
    commit    = 1'b0;
    crcFail   = 1'b0;
    if (rxDataAvail) begin
      case (state)
        HUNT: if (rawFlag) nextState = LEN;
        LEN: begin
          if (dataByte) nextState = lenOk ? TYPE : HUNT;
        end
        TYPE: begin
          if (rawFlag) nextState = LEN;
          else if (dataByte) nextState = typeOk ? BODY : HUNT;
        end
        BODY: begin
          if (rawFlag) nextState = LEN;
          else if (dataByte && bodyLast) nextState = CRC;
        end
        CRC: begin
          if (rawFlag) nextState = LEN;
          else if (dataByte) nextState = END;
        end
        END: begin
          if (rawFlag) begin
            nextState = LEN;
            commit    = crcOk && isControl;
            crcFail   = !crcOk;
          end else begin
            nextState = HUNT;
          end
        end
        default: nextState = HUNT;
      endcase
    end
  end

  // State register
  always_ff @(posedge clock) begin
    if (reset) state <= HUNT;
    else       state <= nextState;
  end

  // Frame datapath: checksum, channel unpacking into shadows, and output commit
  always_ff @(posedge clock) begin
    if (reset) begin
      escPending        <= 1'b0;
      lenReg            <= '0;
      checksum          <= '0;
      isControl         <= 1'b0;
      crcOk             <= 1'b0;
      bodyCount         <= '0;
      bitBuf            <= '0;
      bitCount          <= '0;
      chanIdx           <= '0;
      shadowControls    <= '0;
      shadowRssi        <= '0;
      shadowFrameLoss   <= 1'b1;
      shadowFailsafe    <= 1'b1;
      controls          <= '0;
      rssi              <= '0;
      rxFrameLoss       <= 1'b1;
      failsafeFlag      <= 1'b1;
      controlFrameReady <= 1'b0;
      crcError          <= 1'b0;
    end else begin
      if (rxDataAvail)
        escPending <= inRegion && !rawFlag && !escPending && (rxData == 8'h7D);
      if (dataByte) begin
        case (state)
          LEN: begin
            lenReg    <= destuffed;
            checksum  <= destuffed;
            bodyCount <= '0;
            bitBuf    <= '0;
            bitCount  <= '0;
            chanIdx   <= '0;
          end
          TYPE: begin
            checksum  <= sumNext;
            isControl <= (destuffed == 8'h00);
          end
          BODY: begin
            checksum  <= sumNext;
            bodyCount <= bodyCount + 5'd1;
            if (isControl) begin
              if (bodyCount < 5'd22) begin
                // Channels are packed LSB-first across byte boundaries
                if (chanReady) begin
                  for (int i = 0; i < NUM_CHANNELS; i++)
                    if (chanIdx == 5'(i)) shadowControls[11*i +: 11] <= merged[10:0];
                  bitBuf   <= merged >> 11;
                  bitCount <= mergedCount - 5'd11;
                  chanIdx  <= chanIdx + 5'd1;
                end else begin
                  bitBuf   <= merged;
                  bitCount <= mergedCount;
                end
              end else if (bodyCount == 5'd22) begin
                shadowFrameLoss <= destuffed[2];
                shadowFailsafe  <= destuffed[3];
              end else if (bodyCount == 5'd23) begin
                shadowRssi <= destuffed;
              end
            end
          end
          CRC: crcOk <= (sumNext == 8'hFF);
          default: ;
        endcase
      end
      controlFrameReady <= commit;
      crcError          <= crcFail;
      if (commit) begin
        controls     <= shadowControls;
        rssi         <= shadowRssi;
        rxFrameLoss  <= shadowFrameLoss;
        failsafeFlag <= shadowFailsafe;
      end
    end
  end

  // Link-loss timer: saturates at the timeout and is cleared by each commit
  always_ff @(posedge clock) begin
    if (reset) begin
      timeoutCount <= '0;
      linkTimeout  <= 1'b1;
    end else if (commit) begin
      timeoutCount <= '0;
      linkTimeout  <= 1'b0;
    end else if (timeoutCount != CntWidth'(TimeoutCycles)) begin
      timeoutCount <= timeoutCount + 1'b1;
      if (timeoutCount == CntWidth'(TimeoutCycles - 1)) linkTimeout <= 1'b1;
    end
  end

  assign failsafe = failsafeFlag | linkTimeout;

endmodule

// File: tb/tb_fport_frame_decoder.sv
// Scoreboard bench for fport_frame_decoder: expected commits/CRC errors are queued
// as frames are built and checked when the decoder pulses.
module tb_fport_frame_decoder;

  localparam int NumCh = 4;

  logic                  clock = 1'b0;
  logic                  reset;
  logic [7:0]            rxData;
  logic                  rxDataAvail;
  logic [NumCh*11-1:0]   controls;
  logic                  controlFrameReady;
  logic                  crcError;
  logic [7:0]            rssi;
  logic                  failsafe;
  logic                  rxFrameLoss;
  logic                  linkTimeout;

  fport_frame_decoder #(
    .CLK_FREQ    (16000000),
    .NUM_CHANNELS(NumCh),
    .TIMEOUT_MS  (1)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .rxData           (rxData),
    .rxDataAvail      (rxDataAvail),
    .controls         (controls),
    .controlFrameReady(controlFrameReady),
    .crcError         (crcError),
    .rssi             (rssi),
    .failsafe         (failsafe),
    .rxFrameLoss      (rxFrameLoss),
    .linkTimeout      (linkTimeout)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic                isCrc;
    logic [NumCh*11-1:0] ctl;
    logic [7:0]          rssiVal;
    logic                fs;
    logic                fl;
  } expEvent_t;

  expEvent_t           sbQueue[$];
  expEvent_t           curEvent;
  logic [7:0]          txBytes[$];
  logic [NumCh*11-1:0] modelCtl;
  logic [7:0]          modelRssi;
  logic                modelFs;
  logic                modelFl;
  int                  checkCount = 0;
  int                  errorCount = 0;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  function automatic logic [7:0] addEa(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[7:0] + {7'b0, s[8]};
  endfunction

  function automatic logic [175:0] packCh(input logic [10:0] c0, input logic [10:0] c1,
                                          input logic [10:0] c2, input logic [10:0] c3,
                                          input logic [10:0] rest);
    logic [175:0] bits;
    bits = '0;
    bits[10:0]  = c0;
    bits[21:11] = c1;
    bits[32:22] = c2;
    bits[43:33] = c3;
    for (int i = 4; i < 16; i++) bits[11*i +: 11] = rest;
    return bits;
  endfunction

  task automatic pushStuffed(input logic [7:0] b);
    if (b == 8'h7E || b == 8'h7D) begin
      txBytes.push_back(8'h7D);
      txBytes.push_back(b ^ 8'h20);
    end else begin
      txBytes.push_back(b);
    end
  endtask

  task automatic buildControlFrame(input logic [175:0] chBits, input logic [7:0] flags,
                                   input logic [7:0] rssiVal, input logic [7:0] crcDelta,
                                   input int abortAt);
    logic [7:0] payload[24];
    logic [7:0] sum;
    for (int k = 0; k < 22; k++) payload[k] = chBits[8*k +: 8];
    payload[22] = flags;
    payload[23] = rssiVal;
    txBytes.push_back(8'h7E);
    pushStuffed(8'h19);
    sum = 8'h19;
    pushStuffed(8'h00);
    sum = addEa(sum, 8'h00);
    for (int k = 0; k < 24; k++) begin
      if (k == abortAt) begin
        txBytes.push_back(8'h7E);
        return;
      end
      pushStuffed(payload[k]);
      sum = addEa(sum, payload[k]);
    end
    pushStuffed(8'hFF - sum + crcDelta);
    txBytes.push_back(8'h7E);
  endtask

  task automatic buildShortFrame(input logic [7:0] typ);
    logic [7:0] sum;
    logic [7:0] p;
    txBytes.push_back(8'h7E);
    pushStuffed(8'h08);
    sum = 8'h08;
    pushStuffed(typ);
    sum = addEa(sum, typ);
    for (int k = 0; k < 7; k++) begin
      p = 8'(k * 37 + 5);
      pushStuffed(p);
      sum = addEa(sum, p);
    end
    pushStuffed(8'hFF - sum);
    txBytes.push_back(8'h7E);
  endtask

  task automatic expectCommit(input logic [10:0] c0, input logic [10:0] c1, input logic [10:0] c2,
                              input logic [10:0] c3, input logic [7:0] flags, input logic [7:0] rssiVal);
    expEvent_t e;
    modelCtl  = {c3, c2, c1, c0};
    modelRssi = rssiVal;
    modelFs   = flags[3];
    modelFl   = flags[2];
    e.isCrc   = 1'b0;
    e.ctl     = modelCtl;
    e.rssiVal = modelRssi;
    e.fs      = modelFs;
    e.fl      = modelFl;
    sbQueue.push_back(e);
  endtask

  task automatic expectCrcError();
    expEvent_t e;
    e.isCrc   = 1'b1;
    e.ctl     = modelCtl;
    e.rssiVal = modelRssi;
    e.fs      = modelFs;
    e.fl      = modelFl;
    sbQueue.push_back(e);
  endtask

  task automatic applyStimulus();
    while (txBytes.size() > 0) begin
      @(negedge clock);
      rxData      = txBytes.pop_front();
      rxDataAvail = 1'b1;
    end
    @(negedge clock);
    rxDataAvail = 1'b0;
  endtask

  task automatic settleAndCheck(input string tag);
    repeat (3) @(negedge clock);
    checkOutput(tag, 64'(sbQueue.size()), 64'd0);
  endtask

  // Every pulse must match the oldest queued expectation
  always @(negedge clock) begin
    if (controlFrameReady || crcError) begin
      if (sbQueue.size() == 0) begin
        checkOutput("unexpectedPulse", {62'd0, crcError, controlFrameReady}, 64'd0);
      end else begin
        curEvent = sbQueue.pop_front();
        checkOutput("pulseIsCrcError", 64'(crcError), 64'(curEvent.isCrc));
        checkOutput("pulseIsReady", 64'(controlFrameReady), 64'(!curEvent.isCrc));
        checkOutput("controls", 64'(controls), 64'(curEvent.ctl));
        checkOutput("rssi", 64'(rssi), 64'(curEvent.rssiVal));
        checkOutput("rxFrameLoss", 64'(rxFrameLoss), 64'(curEvent.fl));
        if (!curEvent.isCrc) begin
          checkOutput("failsafe", 64'(failsafe), 64'(curEvent.fs));
          checkOutput("linkTimeout", 64'(linkTimeout), 64'd0);
        end
      end
    end
  end

  task automatic checkResetState(input string tag);
    checkOutput({tag, ".controls"}, 64'(controls), 64'd0);
    checkOutput({tag, ".rssi"}, 64'(rssi), 64'd0);
    checkOutput({tag, ".rxFrameLoss"}, 64'(rxFrameLoss), 64'd1);
    checkOutput({tag, ".failsafe"}, 64'(failsafe), 64'd1);
    checkOutput({tag, ".linkTimeout"}, 64'(linkTimeout), 64'd1);
    checkOutput({tag, ".pulses"}, {62'd0, crcError, controlFrameReady}, 64'd0);
  endtask

  initial begin
    reset       = 1'b1;
    rxData      = 8'h00;
    rxDataAvail = 1'b0;
    modelCtl    = '0;
    modelRssi   = '0;
    modelFs     = 1'b1;
    modelFl     = 1'b1;
    repeat (3) @(negedge clock);
    checkResetState("reset");
    reset = 1'b0;
    @(negedge clock);

    $display("[TB] valid control frame");
    expectCommit(11'h3E0, 11'h400, 11'h000, 11'h000, 8'h00, 8'h55);
    buildControlFrame(packCh(11'h3E0, 11'h400, 11'h000, 11'h000, 11'h000), 8'h00, 8'h55, 8'h00, -1);
    applyStimulus();
    settleAndCheck("validFrameDrained");
    checkOutput("validFrame.ch0", 64'(controls[10:0]), 64'h3E0);
    checkOutput("validFrame.ch1", 64'(controls[21:11]), 64'h400);

    $display("[TB] corrupted CRC byte");
    expectCrcError();
    buildControlFrame(packCh(11'h3E0, 11'h400, 11'h000, 11'h000, 11'h000), 8'h00, 8'h55, 8'h01, -1);
    applyStimulus();
    settleAndCheck("crcErrorDrained");

    $display("[TB] byte-stuffed payload");
    expectCommit(11'h07E, 11'h7A0, 11'h001, 11'h2AA, 8'h0C, 8'h7E);
    buildControlFrame(packCh(11'h07E, 11'h7A0, 11'h001, 11'h2AA, 11'h7FF), 8'h0C, 8'h7E, 8'h00, -1);
    applyStimulus();
    settleAndCheck("stuffedDrained");

    $display("[TB] aborted frame then valid frame");
    buildControlFrame(packCh(11'h111, 11'h222, 11'h333, 11'h444, 11'h555), 8'h00, 8'h10, 8'h00, 10);
    applyStimulus();
    expectCommit(11'h123, 11'h456, 11'h789, 11'h0AB, 8'h04, 8'h99);
    buildControlFrame(packCh(11'h123, 11'h456, 11'h789, 11'h0AB, 11'h000), 8'h04, 8'h99, 8'h00, -1);
    applyStimulus();
    settleAndCheck("abortDrained");

    $display("[TB] telemetry frames and length mismatch");
    buildShortFrame(8'h01);
    buildShortFrame(8'h81);
    buildShortFrame(8'h00);
    applyStimulus();
    settleAndCheck("telemetryNoPulse");
    checkOutput("telemetryKeepsRssi", 64'(rssi), 64'(modelRssi));
    checkOutput("telemetryKeepsControls", 64'(controls), 64'(modelCtl));
    expectCommit(11'h5A5, 11'h0F0, 11'h70F, 11'h001, 8'h00, 8'h42);
    buildControlFrame(packCh(11'h5A5, 11'h0F0, 11'h70F, 11'h001, 11'h3C3), 8'h00, 8'h42, 8'h00, -1);
    applyStimulus();
    settleAndCheck("afterTelemetryDrained");

    $display("[TB] bad end byte");
    buildControlFrame(packCh(11'h001, 11'h002, 11'h003, 11'h004, 11'h000), 8'h00, 8'h11, 8'h00, -1);
    txBytes[txBytes.size()-1] = 8'h00;
    applyStimulus();
    settleAndCheck("badEndNoPulse");
    expectCommit(11'h010, 11'h020, 11'h030, 11'h040, 8'h00, 8'h22);
    buildControlFrame(packCh(11'h010, 11'h020, 11'h030, 11'h040, 11'h000), 8'h00, 8'h22, 8'h00, -1);
    applyStimulus();
    settleAndCheck("afterBadEndDrained");

    $display("[TB] reset mid-frame");
    txBytes.push_back(8'h7E);
    txBytes.push_back(8'h19);
    txBytes.push_back(8'h00);
    applyStimulus();
    @(negedge clock);
    reset       = 1'b1;
    rxData      = 8'h7E;
    rxDataAvail = 1'b1;
    @(negedge clock);
    rxDataAvail = 1'b0;
    @(negedge clock);
    checkResetState("midFrameReset");
    reset     = 1'b0;
    modelCtl  = '0;
    modelRssi = '0;
    modelFs   = 1'b1;
    modelFl   = 1'b1;
    buildControlFrame(packCh(11'h7FF, 11'h7FF, 11'h7FF, 11'h7FF, 11'h000), 8'h00, 8'h33, 8'h00, -1);
    void'(txBytes.pop_front());
    applyStimulus();
    settleAndCheck("noStartAfterReset");
    expectCommit(11'h2B4, 11'h16D, 11'h400, 11'h3FF, 8'h00, 8'h64);
    buildControlFrame(packCh(11'h2B4, 11'h16D, 11'h400, 11'h3FF, 11'h000), 8'h00, 8'h64, 8'h00, -1);
    applyStimulus();

    $display("[TB] link timeout");
    repeat (15998) @(negedge clock);
    checkOutput("beforeTimeout.linkTimeout", 64'(linkTimeout), 64'd0);
    checkOutput("beforeTimeout.failsafe", 64'(failsafe), 64'd0);
    repeat (3) @(negedge clock);
    checkOutput("afterTimeout.linkTimeout", 64'(linkTimeout), 64'd1);
    checkOutput("afterTimeout.failsafe", 64'(failsafe), 64'd1);
    checkOutput("afterTimeout.controlsHeld", 64'(controls), 64'(modelCtl));
    checkOutput("finalQueueEmpty", 64'(sbQueue.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/fport_frame_decoder.md
FPORT_FRAME_DECODER -- requirements
Module: fport_frame_decoder

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 16000000: clock frequency in Hz.
REQ-002 SHALL have parameter NUM_CHANNELS, default 16: number of decoded channels, legal range 1..16.
REQ-003 SHALL have parameter TIMEOUT_MS, default 100: link-loss timeout in milliseconds.
REQ-004 SHALL have port clock  in  1: single clock; all logic on its rising edge.
REQ-005 SHALL have port reset  in  1: synchronous, active-high reset.
REQ-006 SHALL have port rxData  in  8: received UART byte, valid only while rxDataAvail=1.
REQ-007 SHALL have port rxDataAvail  in  1: one-cycle strobe in the clock domain marking a new rxData byte.
REQ-008 SHALL have port controls  out  NUM_CHANNELS*11: channel i at bits [11i+10:11i], registered.
REQ-009 SHALL have port controlFrameReady  out  1: one-cycle pulse when controls/rssi/flags update.
REQ-010 SHALL have port crcError  out  1: one-cycle pulse when a complete frame fails its CRC.
REQ-011 SHALL have port rssi  out  8: RSSI from the last valid control frame.
REQ-012 SHALL have port failsafe  out  1: failsafe flag, forced to 1 while linkTimeout=1.
REQ-013 SHALL have port rxFrameLoss  out  1: frame-loss flag from the last valid control frame.
REQ-014 SHALL have port linkTimeout  out  1: no valid control frame received for TIMEOUT_MS.

Function
REQ-015 SHALL decode streaming with no byte buffer; consume each byte in the cycle of its rxDataAvail strobe.
REQ-016 SHALL implement states HUNT, LEN, TYPE, BODY, CRC, END.
REQ-017 SHALL stay in HUNT until it receives 0x7E, then go to LEN; a further 0x7E in LEN keeps LEN.
REQ-018 SHALL destuff in LEN..CRC: drop 0x7D, XOR the next byte with 0x20, and count only destuffed bytes.
REQ-019 SHALL treat a raw (unstuffed) 0x7E in TYPE, BODY or CRC as abort: discard the frame, go to LEN, no pulses.
REQ-020 SHALL accept LEN only for values 0x19 or 0x08; any other value returns to HUNT.
REQ-021 SHALL accept TYPE 0x00 (control, len 0x19) and types 0x01/0x81 (consumed, outputs untouched); any other type or length mismatch returns to HUNT.
REQ-022 SHALL compute the checksum over len, type and payload as an 8-bit add with end-around carry; the frame is valid iff sum + CRC byte (end-around) = 0xFF.
REQ-023 SHALL unpack control payload bytes 0..21 LSB-first as 11-bit channels; channels >= NUM_CHANNELS are discarded; byte 22 bit2 = rxFrameLoss, bit3 = failsafe; byte 23 = rssi.
REQ-024 SHALL hold decoded values in shadow registers and commit them to outputs only after a valid CRC and a raw 0x7E in END.
REQ-025 SHALL, on commit, update outputs and pulse controlFrameReady in the cycle after the END strobe (latency 1 clock); then go to LEN.
REQ-026 SHALL, when the CRC is bad and END receives 0x7E, pulse crcError in the same cycle position, leave outputs unchanged, then go to LEN.
REQ-027 SHALL return to HUNT if END receives a non-0x7E byte; no pulse.
REQ-028 SHALL count clocks since the last commit, saturating at TIMEOUT_MS*CLK_FREQ/1000; at that value linkTimeout=1 and failsafe=1. A commit clears the counter and linkTimeout in the same cycle.
REQ-029 SHALL ignore cycles with rxDataAvail=0, except for the timeout counter.

Reset
REQ-030 SHALL on reset set state HUNT, controls=0, rssi=0, rxFrameLoss=1, failsafe=1, linkTimeout=1, all pulses 0, and the timeout counter and checksum to 0.
REQ-031 SHALL let reset mid-frame abandon the frame with no pulse, and give reset priority over a simultaneous rxDataAvail.

Verification
REQ-032 SHALL cover: valid control frame, ch0=0x3E0, ch1=0x400, flags=0x00, rssi=0x55 -> one controlFrameReady pulse; controls[10:0]=0x3E0, controls[21:11]=0x400, rssi=0x55, failsafe=0, linkTimeout=0.
REQ-033 SHALL cover: same frame with CRC byte +1 -> crcError pulse; outputs keep their previous values.
REQ-034 SHALL cover: payload containing 0x7E sent as 0x7D 0x5E -> decoded byte 0x7E; CRC passes; the channel value matches.
REQ-035 SHALL cover: raw 0x7E at payload byte 10, then a full valid frame -> first frame dropped silently; second frame commits.
REQ-036 SHALL cover: NUM_CHANNELS=4, TIMEOUT_MS=1, CLK_FREQ=16000000 -> one valid frame, then 16000 idle clocks -> linkTimeout=1, failsafe=1.
REQ-037 SHALL cover: reset asserted after the TYPE byte, then a valid frame -> no pulse during the aborted frame; post-reset outputs as in REQ-030; the later frame commits.
